// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the RV64 5-stage pipeline.
// Owns the PC, issues one outstanding ibus fetch at a time, and buffers
// returned words in a FIFO_DEPTH-entry queue presented to decode.
// A redirect from EX flushes the queue and restarts fetching at the target.
// An in-flight request is drained in DROP and its data discarded.
// Optional feature: define FETCH_BYPASS_EN to forward a response straight to
// decode when the queue is empty, which saves one cycle of fetch latency.
module fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    // instruction bus request
    output logic        ireq_valid_o,
    output logic [63:0] ireq_addr_o,
    // instruction bus response
    input  logic        iresp_addr_ok_i,
    input  logic        iresp_data_ok_i,
    input  logic [31:0] iresp_data_i,
    // redirect from EX
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    // decode handshake
    input  logic        dec_ready_i,
    output logic        dataF_valid_o,
    output logic [63:0] dataF_pc_o,
    output logic [31:0] dataF_instr_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic [63:0]   tgt_q, tgt_d;
    logic          acked_q, acked_d;

    logic [63:0]   mem_pc_q    [FIFO_DEPTH];
    logic [31:0]   mem_instr_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic fifo_empty;
    logic fifo_room;
    logic resp_ok;
    logic resp_take;
    logic bypass_hit;
    logic push;
    logic pop;

    assign fifo_empty = (count_q == '0);
    // Only one request is ever outstanding and none is outstanding in IDLE,
    // so count alone decides whether another word still fits.
    assign fifo_room  = (count_q < CW'(FIFO_DEPTH));

    // A response counts only for a request the bus has accepted (now or
    // earlier) and only while we actually own one; in IDLE a late data_ok,
    // e.g. from a request orphaned by reset, is ignored.
    assign resp_ok = iresp_data_ok_i && (acked_q || iresp_addr_ok_i) &&
                     (state_q != S_IDLE);

    // Fetch FSM: request issue, response capture and redirect handling.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        ireq_valid_o = 1'b0;
        ireq_addr_o  = pc_q;
        resp_take    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                end else if (fifo_room) begin
                    ireq_valid_o = 1'b1;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                ireq_valid_o = 1'b1;
                if (redirect_i) begin
                    if (resp_ok) begin
                        pc_d    = redirect_pc_i;
                        state_d = S_IDLE;
                    end else begin
                        tgt_d   = redirect_pc_i;
                        state_d = S_DROP;
                    end
                end else if (resp_ok) begin
                    resp_take = 1'b1;
                    pc_d      = pc_q + 64'd4;
                    state_d   = S_IDLE;
                end
            end
            S_DROP: begin
                // pc_q still holds the orphaned address so the request stays stable
                ireq_valid_o = 1'b1;
                if (redirect_i) begin
                    tgt_d = redirect_pc_i;
                end
                if (resp_ok) begin
                    pc_d    = redirect_i ? redirect_pc_i : tgt_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (reset_i) begin
            ireq_valid_o = 1'b0;
        end
    end

    // Track whether the current request's address phase has completed.
    always_comb begin
        acked_d = acked_q;
        if (ireq_valid_o && iresp_addr_ok_i) begin
            acked_d = 1'b1;
        end
        if (state_d == S_IDLE) begin
            acked_d = 1'b0;
        end
    end

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = resp_take && fifo_empty;
`else
    assign bypass_hit = 1'b0;
`endif

    // Decode view: queue head, or the live response when bypassing.
    always_comb begin
        dataF_valid_o = !fifo_empty || bypass_hit;
        dataF_pc_o    = '0;
        dataF_instr_o = '0;
        if (bypass_hit) begin
            dataF_pc_o    = pc_q;
            dataF_instr_o = iresp_data_i;
        end else if (!fifo_empty) begin
            dataF_pc_o    = mem_pc_q[rd_ptr_q];
            dataF_instr_o = mem_instr_q[rd_ptr_q];
        end
    end

    // A bypassed word that decode takes immediately never enters the queue.
    assign push = resp_take && !(bypass_hit && dec_ready_i);
    assign pop  = !fifo_empty && dec_ready_i && !redirect_i;

    // Queue pointer/count update; a redirect empties the queue outright.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            count_d  = count_q + CW'(push) - CW'(pop);
        end
    end

    // State, PC and queue control registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            tgt_q    <= RESET_PC;
            acked_q  <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            tgt_q    <= tgt_d;
            acked_q  <= acked_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage; contents need no reset since the outputs are gated by count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]    <= pc_q;
            mem_instr_q[wr_ptr_q] <= iresp_data_i;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle table for the zero-wait startup, directed
// multi-cycle corner sequences, then a randomized run against a stream model.
module tb_fetch_stage;

    localparam logic [63:0] RPC   = 64'h0000_0000_8000_0000;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        dec_ready;
    logic        dataF_valid;
    logic [63:0] dataF_pc;
    logic [31:0] dataF_instr;

    always #5 clk = ~clk;

    // The bus takes every address immediately.
    assign addr_ok = ireq_valid;

    fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .ireq_valid_o    (ireq_valid),
        .ireq_addr_o     (ireq_addr),
        .iresp_addr_ok_i (addr_ok),
        .iresp_data_ok_i (data_ok),
        .iresp_data_i    (data),
        .redirect_i      (redirect),
        .redirect_pc_i   (redirect_pc),
        .dec_ready_i     (dec_ready),
        .dataF_valid_o   (dataF_valid),
        .dataF_pc_o      (dataF_pc),
        .dataF_instr_o   (dataF_instr)
    );

    typedef struct {
        logic        dr;
        logic        iv;
        logic [63:0] ia;
        logic        dv;
        logic [63:0] dp;
    } vec_t;

    vec_t tbl [7];

    int n_pass = 0;
    int n_total = 0;

    // bus model
    bit          bus_busy;
    int          bus_cnt;
    logic [63:0] bus_addr;
    int          lat_lo, lat_hi;

    // stream model: next pc decode should see, next address to be fetched
    logic [63:0] exp_pc, exp_fetch;
    bit          prev_redir;
    int          delivered;
    logic [63:0] acc_log [$];

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_true(input string name, input bit ok, input int act);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: condition false (value %0d)", name, act);
    endtask

    task automatic settle();
        data_ok = bus_busy && (bus_cnt == 0);
        data    = word_at(bus_addr);
        #1;
    endtask

    task automatic finish_cycle();
        bit was_busy;
        was_busy = bus_busy;
        if (was_busy) begin
            chk("hold_valid", ireq_valid, 1'b1);
            chk("hold_addr", ireq_addr, bus_addr);
        end
        if (prev_redir) chk("flush_valid", dataF_valid, 1'b0);
        if (dataF_valid && dec_ready && !redirect) begin
            chk("dataF_pc", dataF_pc, exp_pc);
            chk("dataF_instr", dataF_instr, word_at(exp_pc));
            exp_pc = exp_pc + 64'd4;
            delivered++;
        end
        if (ireq_valid && !was_busy) begin
            chk("req_addr", ireq_addr, exp_fetch);
            exp_fetch = exp_fetch + 64'd4;
            acc_log.push_back(ireq_addr);
            bus_busy = 1'b1;
            bus_addr = ireq_addr;
            bus_cnt  = $urandom_range(lat_hi - 1, lat_lo - 1);
        end else if (data_ok) begin
            bus_busy = 1'b0;
        end else if (bus_busy && bus_cnt > 0) begin
            bus_cnt--;
        end
        if (redirect) begin
            exp_pc    = redirect_pc;
            exp_fetch = redirect_pc;
        end
        prev_redir = redirect;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        settle();
        finish_cycle();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        dec_ready   = 1'b0;
        data_ok     = 1'b0;
        data        = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ireq_valid", ireq_valid, 1'b0);
        chk("rst_dataF_valid", dataF_valid, 1'b0);
        chk("rst_dataF_pc", dataF_pc, 64'd0);
        reset      = 1'b0;
        bus_busy   = 1'b0;
        bus_cnt    = 0;
        bus_addr   = '0;
        exp_pc     = RPC;
        exp_fetch  = RPC;
        prev_redir = 1'b0;
    endtask

    task automatic chk_acc(input string name, input int idx, input logic [63:0] exp);
        if (acc_log.size() > idx) chk(name, acc_log[idx], exp);
        else chk_true(name, 1'b0, acc_log.size());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, d0;
        delivered = 0;
        lat_lo = 1;
        lat_hi = 1;

        // 1: zero-wait bus, decode always ready, cycle by cycle
`ifdef FETCH_BYPASS_EN
        tbl[0] = '{1'b1, 1'b1, RPC,        1'b0, 64'd0};
        tbl[1] = '{1'b1, 1'b1, RPC,        1'b1, RPC};
        tbl[2] = '{1'b1, 1'b1, RPC + 4,    1'b0, 64'd0};
        tbl[3] = '{1'b1, 1'b1, RPC + 4,    1'b1, RPC + 4};
        tbl[4] = '{1'b1, 1'b1, RPC + 8,    1'b0, 64'd0};
        tbl[5] = '{1'b1, 1'b1, RPC + 8,    1'b1, RPC + 8};
        tbl[6] = '{1'b1, 1'b1, RPC + 12,   1'b0, 64'd0};
`else
        tbl[0] = '{1'b1, 1'b1, RPC,        1'b0, 64'd0};
        tbl[1] = '{1'b1, 1'b1, RPC,        1'b0, 64'd0};
        tbl[2] = '{1'b1, 1'b1, RPC + 4,    1'b1, RPC};
        tbl[3] = '{1'b1, 1'b1, RPC + 4,    1'b0, 64'd0};
        tbl[4] = '{1'b1, 1'b1, RPC + 8,    1'b1, RPC + 4};
        tbl[5] = '{1'b1, 1'b1, RPC + 8,    1'b0, 64'd0};
        tbl[6] = '{1'b1, 1'b1, RPC + 12,   1'b1, RPC + 8};
`endif
        do_reset();
        for (int i = 0; i < 7; i++) begin
            dec_ready = tbl[i].dr;
            redirect  = 1'b0;
            settle();
            chk($sformatf("t1_ireq_valid[%0d]", i), ireq_valid, tbl[i].iv);
            chk($sformatf("t1_ireq_addr[%0d]", i), ireq_addr, tbl[i].ia);
            chk($sformatf("t1_dataF_valid[%0d]", i), dataF_valid, tbl[i].dv);
            if (tbl[i].dv) chk($sformatf("t1_dataF_pc[%0d]", i), dataF_pc, tbl[i].dp);
            finish_cycle();
        end

        // 2: decode stalls for 10 cycles, then releases
        dec_ready = 1'b0;
        repeat (9) tick();
        settle();
        chk("t2_stall_no_req", ireq_valid, 1'b0);
        chk("t2_buffered_words", (exp_fetch - exp_pc) >> 2, DEPTH);
        chk("t2_head_valid", dataF_valid, 1'b1);
        finish_cycle();
        d0 = delivered;
        dec_ready = 1'b1;
        repeat (12) tick();
        chk_true("t2_resume", delivered >= d0 + DEPTH + 2, delivered - d0);

        // 3: redirect while the request waits on a slow bus
        do_reset();
        lat_lo = 3;
        lat_hi = 3;
        dec_ready = 1'b1;
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'h0000_0000_8000_1000;
        tick();
        redirect = 1'b0;
        a0 = acc_log.size();
        d0 = delivered;
        repeat (10) tick();
        chk_acc("t3_first_addr", a0, 64'h0000_0000_8000_1000);
        chk_true("t3_delivered", delivered > d0, delivered - d0);

        // 4: redirect coincides with data_ok that would fill the queue
        do_reset();
        lat_lo = 1;
        lat_hi = 1;
        dec_ready = 1'b0;
        repeat (3) tick();
        redirect    = 1'b1;
        redirect_pc = 64'h0000_0000_8000_2000;
        settle();
        chk("t4_head_before", dataF_valid, 1'b1);
        finish_cycle();
        redirect  = 1'b0;
        dec_ready = 1'b1;
        a0 = acc_log.size();
        settle();
        chk("t4_flushed", dataF_valid, 1'b0);
        finish_cycle();
        repeat (6) tick();
        chk_acc("t4_restart_addr", a0, 64'h0000_0000_8000_2000);

        // 5: PC wrap-around at the top of the address space
        do_reset();
        dec_ready = 1'b1;
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        tick();
        redirect = 1'b0;
        a0 = acc_log.size();
        repeat (12) tick();
        chk_acc("t5_addr_fff8", a0,     64'hFFFF_FFFF_FFFF_FFF8);
        chk_acc("t5_addr_fffc", a0 + 1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk_acc("t5_addr_wrap", a0 + 2, 64'h0);

        // 6: reset while a request is outstanding; late data_ok must be ignored
        do_reset();
        lat_lo = 5;
        lat_hi = 5;
        dec_ready = 1'b0;
        tick();
        tick();
        reset   = 1'b1;
        data_ok = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_rst_valid", ireq_valid, 1'b0);
        chk("t6_rst_dataF", dataF_valid, 1'b0);
        reset   = 1'b0;
        data_ok = 1'b1;
        data    = 32'hDEAD_BEEF;
        #1;
        chk("t6_restart_valid", ireq_valid, 1'b1);
        chk("t6_restart_addr", ireq_addr, RPC);
        chk("t6_no_forward", dataF_valid, 1'b0);
        @(posedge clk);
        #1;
        data_ok = 1'b0;
        #1;
        chk("t6_late_dropped", dataF_valid, 1'b0);
        @(posedge clk);
        #1;

        // random traffic against the stream model
        do_reset();
        lat_lo = 1;
        lat_hi = 4;
        d0 = delivered;
        for (int i = 0; i < 400; i++) begin
            dec_ready = ($urandom_range(9, 0) < 7);
            redirect  = ($urandom_range(19, 0) == 0);
            case ($urandom_range(3, 0))
                0: redirect_pc = RPC + 64'({$urandom_range(255, 0), 2'b00});
                1: redirect_pc = {$urandom, $urandom};
                2: redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15, 0));
                default: redirect_pc = RPC + 64'($urandom_range(63, 0)) * 4 + 64'($urandom_range(3, 1));
            endcase
            tick();
        end
        redirect  = 1'b0;
        dec_ready = 1'b1;
        repeat (20) tick();
        chk_true("rand_progress", delivered - d0 > 50, delivered - d0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
